canny_point_stream: RTL and testbench

CANNY_POINT_STREAM -- requirements
Module: canny_point_stream

---
 rtl/canny_point_stream.sv | 166 ++++++++++++++++
 tb/tb_canny_point_stream.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/canny_point_stream.sv
// canny_point_stream: banked {x,y} point memory streamed out over a valid/ready handshake.
// Ports: clk, reset (sync, active-high); wr_en/wr_bank/wr_addr/wr_x/wr_y point write;
// len_we/len_bank/len_val per-bank point count; start/start_bank/abort stream control;
// pt_valid/pt_x/pt_y/pt_idx/pt_last point stream with pt_ready; busy, frame_done, wr_err status.
// Option: CANNY_STREAM_LOOP_EN adds loop_en, which replays the bank continuously while high.
module canny_point_stream #(
    parameter int W_COORD = 16,
    parameter int DEPTH   = 64,
    parameter int N_BANK  = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = (N_BANK > 1) ? $clog2(N_BANK) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [BW-1:0]      wr_bank,
    input  logic [AW-1:0]      wr_addr,
    input  logic [W_COORD-1:0] wr_x,
    input  logic [W_COORD-1:0] wr_y,
    input  logic               len_we,
    input  logic [BW-1:0]      len_bank,
    input  logic [AW:0]        len_val,
    input  logic               start,
    input  logic [BW-1:0]      start_bank,
    input  logic               abort,
`ifdef CANNY_STREAM_LOOP_EN
    input  logic               loop_en,
`endif
    output logic               pt_valid,
    output logic [W_COORD-1:0] pt_x,
    output logic [W_COORD-1:0] pt_y,
    output logic [AW-1:0]      pt_idx,
    output logic               pt_last,
    input  logic               pt_ready,
    output logic               busy,
    output logic               frame_done,
    output logic               wr_err
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    state_t state_q, state_d;
    logic [W_COORD-1:0] mem_x_q [N_BANK][DEPTH];
    logic [W_COORD-1:0] mem_y_q [N_BANK][DEPTH];
    logic [AW:0] len_q [N_BANK];
    logic [BW-1:0] bank_q, bank_d;
    logic [AW:0] llen_q, llen_d;
    logic pt_valid_q, pt_valid_d, pt_last_q, pt_last_d;
    logic [W_COORD-1:0] pt_x_q, pt_x_d, pt_y_q, pt_y_d;
    logic [AW-1:0] pt_idx_q, pt_idx_d, nidx;
    logic frame_done_q, frame_done_d, wr_err_q, wr_err_d;
    logic [BW-1:0] wb, lb, sb;
    logic [AW:0] slen;
    logic wr_hit, len_hit, wr_ok, len_ok, xfer;
    // A single-bank build ignores every bank select.
    assign wb = (N_BANK == 1) ? '0 : wr_bank;
    assign lb = (N_BANK == 1) ? '0 : len_bank;
    assign sb = (N_BANK == 1) ? '0 : start_bank;
    assign busy = state_q != IDLE;
    // Writes into the bank being streamed are refused so the image stays coherent.
    assign wr_hit = busy && wb == bank_q;
    assign len_hit = busy && lb == bank_q;
    assign wr_ok = wr_en && !wr_hit;
    assign len_ok = len_we && !len_hit;
    assign wr_err_d = (wr_en && wr_hit) || (len_we && len_hit);
    assign slen = len_q[sb];
    assign nidx = pt_idx_q + AW'(1);
    assign xfer = pt_valid_q && pt_ready;
    always_comb begin
        state_d = state_q;
        bank_d = bank_q;
        llen_d = llen_q;
        pt_valid_d = pt_valid_q;
        pt_x_d = pt_x_q;
        pt_y_d = pt_y_q;
        pt_idx_d = pt_idx_q;
        pt_last_d = pt_last_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && slen == '0) begin
                    state_d = DONE;
                    frame_done_d = 1'b1;
                end else if (start) begin
                    state_d = STREAM;
                    bank_d = sb;
                    llen_d = slen;
                    pt_valid_d = 1'b1;
                    pt_x_d = mem_x_q[sb][0];
                    pt_y_d = mem_y_q[sb][0];
                    pt_idx_d = '0;
                    pt_last_d = slen == (AW+1)'(1);
                end
            end
            STREAM: begin
                // Abort wins over a transfer in the same cycle.
                if (abort) begin
                    state_d = IDLE;
                    pt_valid_d = 1'b0;
                end else if (xfer && !pt_last_q) begin
                    pt_x_d = mem_x_q[bank_q][nidx];
                    pt_y_d = mem_y_q[bank_q][nidx];
                    pt_idx_d = nidx;
                    pt_last_d = {1'b0, nidx} == llen_q - (AW+1)'(1);
                end else if (xfer) begin
                    frame_done_d = 1'b1;
`ifdef CANNY_STREAM_LOOP_EN
                    if (loop_en) begin
                        pt_x_d = mem_x_q[bank_q][0];
                        pt_y_d = mem_y_q[bank_q][0];
                        pt_idx_d = '0;
                        pt_last_d = llen_q == (AW+1)'(1);
                    end else begin
                        state_d = DONE;
                        pt_valid_d = 1'b0;
                    end
`else
                    state_d = DONE;
                    pt_valid_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bank_q <= '0;
            llen_q <= '0;
            pt_valid_q <= 1'b0;
            pt_x_q <= '0;
            pt_y_q <= '0;
            pt_idx_q <= '0;
            pt_last_q <= 1'b0;
            frame_done_q <= 1'b0;
            wr_err_q <= 1'b0;
            for (int i = 0; i < N_BANK; i++) len_q[i] <= '0;
        end else begin
            state_q <= state_d;
            bank_q <= bank_d;
            llen_q <= llen_d;
            pt_valid_q <= pt_valid_d;
            pt_x_q <= pt_x_d;
            pt_y_q <= pt_y_d;
            pt_idx_q <= pt_idx_d;
            pt_last_q <= pt_last_d;
            frame_done_q <= frame_done_d;
            wr_err_q <= wr_err_d;
            if (len_ok) len_q[lb] <= (len_val > DEPTH_L) ? DEPTH_L : len_val;
        end
    end
    // Point memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_x_q[wb][wr_addr] <= wr_x;
            mem_y_q[wb][wr_addr] <= wr_y;
        end
    end
    assign pt_valid = pt_valid_q;
    assign pt_x = pt_x_q;
    assign pt_y = pt_y_q;
    assign pt_idx = pt_idx_q;
    assign pt_last = pt_last_q;
    assign frame_done = frame_done_q;
    assign wr_err = wr_err_q;
endmodule

// File: tb/tb_canny_point_stream.sv
// tb_canny_point_stream: scoreboard bench for canny_point_stream.
module tb_canny_point_stream;
    localparam int W = 16, D = 64, NB = 2, AW = 6, BW = 1;
    logic clk = 1'b0, reset = 1'b1;
    logic wr_en = 1'b0, len_we = 1'b0, start = 1'b0, abort = 1'b0, pt_ready = 1'b0;
    logic [BW-1:0] wr_bank = '0, len_bank = '0, start_bank = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0] wr_x = '0, wr_y = '0;
    logic [AW:0] len_val = '0;
`ifdef CANNY_STREAM_LOOP_EN
    logic loop_en = 1'b0;
`endif
    logic pt_valid, pt_last, busy, frame_done, wr_err;
    logic [W-1:0] pt_x, pt_y;
    logic [AW-1:0] pt_idx;
    typedef struct packed {logic [W-1:0] x; logic [W-1:0] y; logic [AW-1:0] idx; logic last;} ent_t;
    ent_t exp_q[$];
    int xcyc[$];
    logic [W-1:0] mx [NB][D];
    logic [W-1:0] my [NB][D];
    int compared = 0, mismatched = 0, cyc = 0;
    int fd_cnt = 0, err_cnt = 0, valid_cnt = 0, hold_cnt = 0, fd_cyc = -1;
    logic stall_q = 1'b0;
    ent_t held;

    canny_point_stream #(.W_COORD(W), .DEPTH(D), .N_BANK(NB)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
        .len_we(len_we), .len_bank(len_bank), .len_val(len_val),
        .start(start), .start_bank(start_bank), .abort(abort),
`ifdef CANNY_STREAM_LOOP_EN
        .loop_en(loop_en),
`endif
        .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y), .pt_idx(pt_idx), .pt_last(pt_last),
        .pt_ready(pt_ready), .busy(busy), .frame_done(frame_done), .wr_err(wr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted point, checks stall stability.
    always @(negedge clk) begin
        ent_t cur, e;
        cur = {pt_x, pt_y, pt_idx, pt_last};
        if (!reset) begin
            if (pt_valid) valid_cnt++;
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (wr_err) err_cnt++;
            if (stall_q && pt_valid) begin
                hold_cnt++;
                chk("hold_stable", cur, held);
            end
            if (pt_valid && pt_ready && !abort) begin
                if (exp_q.size() == 0) chk("sb_nonempty", 0, 1);
                else begin
                    e = exp_q.pop_front();
                    chk("point", cur, e);
                end
                xcyc.push_back(cyc);
            end
            stall_q = pt_valid && !pt_ready && !abort;
            held = cur;
        end else stall_q = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_pt(input int b, input int a, input int x, input int y, input bit ok);
        wr_en = 1'b1;
        wr_bank = BW'(b);
        wr_addr = AW'(a);
        wr_x = W'(x);
        wr_y = W'(y);
        tick();
        wr_en = 1'b0;
        if (ok) begin
            mx[b][a] = W'(x);
            my[b][a] = W'(y);
        end
    endtask

    task automatic set_len(input int b, input int v);
        len_we = 1'b1;
        len_bank = BW'(b);
        len_val = (AW+1)'(v);
        tick();
        len_we = 1'b0;
    endtask

    task automatic push_stream(input int b, input int cnt, input int len);
        ent_t e;
        for (int i = 0; i < cnt; i++) begin
            e.x = mx[b][i];
            e.y = my[b][i];
            e.idx = AW'(i % len);
            e.last = (i % len) == len - 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic go(input int b);
        start = 1'b1;
        start_bank = BW'(b);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int f0, input int bound);
        for (int i = 0; i < bound && fd_cnt == f0; i++) tick();
        chk(tag, fd_cnt > f0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int x0, f0, v0, h0, e0;
        repeat (3) tick();
        chk("rst_valid", pt_valid, 0);
        chk("rst_x", pt_x, 0);
        chk("rst_y", pt_y, 0);
        chk("rst_idx", pt_idx, 0);
        chk("rst_last", pt_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_err", wr_err, 0);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) wr_pt(0, i, 50 * i, 800 - 80 * i, 1'b1);
        for (int i = 0; i < D; i++) wr_pt(1, i, 1000 + i, 2000 + 3 * i, 1'b1);
        set_len(0, 10);

        // Bank0 full stream, ready held high.
        x0 = xcyc.size(); f0 = fd_cnt;
        push_stream(0, 10, 10);
        pt_ready = 1'b1;
        go(0);
        wait_fd("t1_done", f0, 40);
        chk("t1_xfers", xcyc.size() - x0, 10);
        chk("t1_sb_empty", exp_q.size(), 0);
        chk("t1_back2back", (xcyc.size() >= x0 + 10) ? xcyc[x0 + 9] - xcyc[x0] : -1, 9);
        chk("t1_fd_timing", fd_cyc - xcyc[xcyc.size() - 1], 1);
        chk("t1_busy", busy, 0);
        tick(); tick();
        chk("t1_fd_once", fd_cnt - f0, 1);

        // Same stream with ready toggling.
        x0 = xcyc.size(); f0 = fd_cnt; h0 = hold_cnt;
        push_stream(0, 10, 10);
        pt_ready = 1'b0;
        go(0);
        for (int i = 0; i < 60 && fd_cnt == f0; i++) begin
            pt_ready = ~pt_ready;
            tick();
        end
        chk("t2_done", fd_cnt > f0, 1);
        chk("t2_xfers", xcyc.size() - x0, 10);
        chk("t2_sb_empty", exp_q.size(), 0);
        chk("t2_stalls_seen", hold_cnt > h0, 1);

        // Zero length bank: frame_done with no point.
        set_len(1, 0);
        x0 = xcyc.size(); f0 = fd_cnt; v0 = valid_cnt;
        pt_ready = 1'b1;
        go(1);
        wait_fd("t3_done", f0, 10);
        chk("t3_no_valid", valid_cnt - v0, 0);
        chk("t3_no_xfer", xcyc.size() - x0, 0);

        // Oversized length clamps to DEPTH.
        set_len(1, D + 1);
        x0 = xcyc.size(); f0 = fd_cnt;
        push_stream(1, D, D);
        go(1);
        wait_fd("t4_done", f0, 200);
        chk("t4_xfers", xcyc.size() - x0, D);
        chk("t4_sb_empty", exp_q.size(), 0);

        // Writes during a bank0 stream, then abort at idx 4.
        x0 = xcyc.size(); f0 = fd_cnt; e0 = err_cnt;
        pt_ready = 1'b0;
        push_stream(0, 4, 10);
        go(0);
        chk("t5_busy", busy, 1);
        go(1);
        chk("t5_start_ignored_idx", pt_idx, 0);
        chk("t5_start_ignored_x", pt_x, mx[0][0]);
        wr_pt(0, 2, 9999, 9999, 1'b0);
        chk("t5_wr_err", wr_err, 1);
        tick();
        chk("t5_wr_err_pulse", wr_err, 0);
        set_len(0, 3);
        chk("t5_len_err", wr_err, 1);
        wr_pt(1, 5, 7777, 7778, 1'b1);
        chk("t5_other_bank_ok", wr_err, 0);
        pt_ready = 1'b1;
        repeat (4) tick();
        chk("t5_at_idx4", pt_idx, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_valid", pt_valid, 0);
        chk("t5_abort_busy", busy, 0);
        repeat (3) tick();
        chk("t5_no_fd", fd_cnt - f0, 0);
        chk("t5_xfers", xcyc.size() - x0, 4);
        chk("t5_err_count", err_cnt - e0, 2);
        chk("t5_sb_empty", exp_q.size(), 0);

        // Bank0 data and length untouched by the refused writes.
        x0 = xcyc.size(); f0 = fd_cnt;
        push_stream(0, 10, 10);
        go(0);
        wait_fd("t6_done", f0, 40);
        chk("t6_xfers", xcyc.size() - x0, 10);

        // Bank1 write made during the bank0 stream landed.
        set_len(1, 6);
        x0 = xcyc.size(); f0 = fd_cnt;
        push_stream(1, 6, 6);
        go(1);
        wait_fd("t7_done", f0, 30);
        chk("t7_xfers", xcyc.size() - x0, 6);
        chk("t7_sb_empty", exp_q.size(), 0);

`ifdef CANNY_STREAM_LOOP_EN
        set_len(0, 3);
        x0 = xcyc.size(); f0 = fd_cnt;
        push_stream(0, 6, 3);
        loop_en = 1'b1;
        go(0);
        repeat (5) tick();
        loop_en = 1'b0;
        for (int i = 0; i < 20 && fd_cnt < f0 + 2; i++) tick();
        tick();
        chk("t8_fd_twice", fd_cnt - f0, 2);
        chk("t8_xfers", xcyc.size() - x0, 6);
        chk("t8_no_bubble", (xcyc.size() >= x0 + 6) ? xcyc[x0 + 5] - xcyc[x0] : -1, 5);
        chk("t8_busy", busy, 0);
        chk("t8_sb_empty", exp_q.size(), 0);
`endif

        // Reset mid-stream discards the stream and clears lengths.
        f0 = fd_cnt;
        pt_ready = 1'b0;
        go(0);
        chk("t9_valid_before", pt_valid, 1);
        reset = 1'b1;
        tick();
        chk("t9_rst_valid", pt_valid, 0);
        chk("t9_rst_busy", busy, 0);
        chk("t9_rst_fd", frame_done, 0);
        reset = 1'b0;
        tick();
        chk("t9_no_fd", fd_cnt - f0, 0);
        v0 = valid_cnt;
        pt_ready = 1'b1;
        go(0);
        wait_fd("t9_len_cleared_done", f0, 10);
        chk("t9_len_cleared", valid_cnt - v0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
